song_session_ctrl: RTL and testbench

- Top-level sequencer for one song session: Idle, Countdown, Play, Pause and End-hold.
- Owns the song timebase.
- Derives a clean one-cycle frame_tick from the asynchronous new_frame (VGA vsync) into the clk domain, so no logic is clocked by new_frame.
- Publishes song_time to the note/scoring datapath and gates audio playback.

---
 rtl/song_ctrl_pkg.sv | 6 +
 rtl/frame_tick_sync.sv | 22 ++
 rtl/song_session_ctrl.sv | 118 +++++++++++
 tb/tb_song_session_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/song_ctrl_pkg.sv
// song_ctrl_pkg: shared session state encoding and default song timing constants
package song_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_COUNTDOWN, S_PLAY, S_PAUSE, S_END_HOLD} state_e;
  localparam int SONG_LEN_DEF = 5669;
  localparam int FPS_DEF = 60;
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: brings the asynchronous vsync level into clk and emits one registered pulse per rising edge
module frame_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic new_frame_i,
  output logic frame_tick_o
);
  logic s1_q, s2_q, s3_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      frame_tick_o <= 1'b0;
    end else begin
      s1_q <= new_frame_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      frame_tick_o <= s2_q & ~s3_q;
    end
  end
endmodule

// File: rtl/song_session_ctrl.sv
// song_session_ctrl: song session sequencer owning the song timebase, countdown and audio gating
module song_session_ctrl
  import song_ctrl_pkg::*;
#(
  parameter int TIME_W = 16,
  parameter int SONG_LEN = SONG_LEN_DEF,
  parameter int FPS = FPS_DEF,
  parameter int COUNTDOWN_SEC = 3,
  parameter int END_HOLD_FRAMES = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_frame,
  input  logic              start_key,
  input  logic              pause_key,
  input  logic              abort_key,
  output logic              frame_tick,
  output logic [TIME_W-1:0] song_time,
  output logic [1:0]        countdown_sec,
  output logic              audio_run,
  output logic              song_done,
  output logic [2:0]        state_o
);
  localparam int SUB_W = $clog2(FPS + 1);
  localparam int HOLD_W = $clog2(END_HOLD_FRAMES + 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(FPS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(END_HOLD_FRAMES - 1);
  localparam logic [TIME_W-1:0] LEN = TIME_W'(SONG_LEN);
  localparam logic [1:0] CSEC = 2'(COUNTDOWN_SEC);
  state_e state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [1:0] csec_q, csec_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic done_q, done_d;
  logic start_q, pause_q, abort_q;
  logic abort_e, pause_e, start_e, load_cd;
  frame_tick_sync u_sync (
    .clk(clk),
    .rst(reset),
    .new_frame_i(new_frame),
    .frame_tick_o(frame_tick)
  );
  assign abort_e = abort_key & ~abort_q;
  assign pause_e = pause_key & ~pause_q & ~abort_e;
  assign start_e = start_key & ~start_q & ~abort_e & ~pause_e;
  assign load_cd = ((state_q == S_IDLE || state_q == S_END_HOLD) && start_e) ||
                   (state_q == S_PAUSE && (pause_e || start_e));
  always_comb begin
    state_d = state_q;
    time_d = time_q;
    csec_d = csec_q;
    sub_d = sub_q;
    hold_d = hold_q;
    done_d = 1'b0;
    case (state_q)
      S_COUNTDOWN: if (frame_tick) begin
        sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + 1'b1;
        csec_d = (sub_q == SUB_LAST) ? csec_q - 1'b1 : csec_q;
        state_d = (sub_q == SUB_LAST && csec_q == 2'd1) ? S_PLAY : S_COUNTDOWN;
      end
      S_PLAY: if (frame_tick && time_q == LEN) begin
        state_d = S_END_HOLD;
        done_d = 1'b1;
        hold_d = '0;
      end else begin
        time_d = frame_tick ? time_q + 1'b1 : time_q;
        state_d = pause_e ? S_PAUSE : S_PLAY;
      end
      S_END_HOLD: if (frame_tick) begin
        hold_d = hold_q + 1'b1;
        state_d = (hold_q == HOLD_LAST) ? S_IDLE : S_END_HOLD;
        time_d = (hold_q == HOLD_LAST) ? '0 : time_q;
      end
      default: ;
    endcase
    // a resume from Pause keeps its place in the song; every other countdown starts from zero
    if (load_cd) begin
      state_d = S_COUNTDOWN;
      csec_d = CSEC;
      sub_d = '0;
      time_d = (state_q == S_PAUSE) ? time_q : '0;
    end
    if (abort_e && state_q != S_IDLE) begin
      state_d = S_IDLE;
      time_d = '0;
      csec_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      time_q <= '0;
      csec_q <= '0;
      sub_q <= '0;
      hold_q <= '0;
      done_q <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q <= time_d;
      csec_q <= csec_d;
      sub_q <= sub_d;
      hold_q <= hold_d;
      done_q <= done_d;
      start_q <= start_key;
      pause_q <= pause_key;
      abort_q <= abort_key;
    end
  end
  assign song_time = time_q;
  assign countdown_sec = csec_q;
  assign audio_run = (state_q == S_PLAY);
  assign song_done = done_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_song_session_ctrl.sv
// tb_song_session_ctrl: directed plus randomized checks of two session controllers against a frame-level reference model
module tb_song_session_ctrl;
  import song_ctrl_pkg::*;
  localparam int FPS = 60, CD = 3, EH = 4, LEN_S = 10, LEN_L = 5669;
  logic clk = 1'b0, reset = 1'b1, nf = 1'b0, sk = 1'b0, pk = 1'b0, ak = 1'b0;
  logic ft_s, ar_s, sd_s, ft_l, ar_l, sd_l;
  logic [15:0] tm_s, tm_l;
  logic [1:0] cs_s, cs_l;
  logic [2:0] so_s, so_l;
  logic [23:0] obs_s, obs_l;
  int n_chk = 0, n_err = 0, n_done = 0, n_tick = 0, n_rise = 0;
  logic ft_prev = 1'b0;
  state_e m_st[2];
  int m_tm[2], m_rem[2], m_hold[2];
  bit m_done[2];
  bit m_ft, p_s, p_p, p_a;
  bit h[4];
  always #5 clk = ~clk;
  song_session_ctrl #(.TIME_W(16), .SONG_LEN(LEN_S), .FPS(FPS), .COUNTDOWN_SEC(CD), .END_HOLD_FRAMES(EH)) dut_s (
    .clk(clk), .reset(reset), .new_frame(nf), .start_key(sk), .pause_key(pk), .abort_key(ak),
    .frame_tick(ft_s), .song_time(tm_s), .countdown_sec(cs_s), .audio_run(ar_s), .song_done(sd_s), .state_o(so_s));
  song_session_ctrl #(.TIME_W(16), .SONG_LEN(LEN_L), .FPS(FPS), .COUNTDOWN_SEC(CD), .END_HOLD_FRAMES(EH)) dut_l (
    .clk(clk), .reset(reset), .new_frame(nf), .start_key(sk), .pause_key(pk), .abort_key(ak),
    .frame_tick(ft_l), .song_time(tm_l), .countdown_sec(cs_l), .audio_run(ar_l), .song_done(sd_l), .state_o(so_l));
  assign obs_s = {so_s, tm_s, cs_s, ar_s, sd_s, ft_s};
  assign obs_l = {so_l, tm_l, cs_l, ar_l, sd_l, ft_l};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] exp_vec(input int i);
    int cs;
    cs = (m_st[i] == S_COUNTDOWN) ? (m_rem[i] + FPS - 1) / FPS : 0;
    return {m_st[i], 16'(m_tm[i]), 2'(cs), m_st[i] == S_PLAY, m_done[i], m_ft};
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE;
      m_tm[i] = 0;
      m_rem[i] = 0;
      m_hold[i] = 0;
      m_done[i] = 0;
    end
    m_ft = 0;
    p_s = 0;
    p_p = 0;
    p_a = 0;
    for (int j = 0; j < 4; j++) h[j] = 0;
  endtask
  // one clk edge: tick consumed now is the vsync rise seen three samples ago
  task automatic model_edge();
    bit tick, ab, pa, st;
    int len;
    tick = h[2] & ~h[3];
    ab = ak & ~p_a;
    pa = pk & ~p_p & ~ab;
    st = sk & ~p_s & ~ab & ~pa;
    for (int i = 0; i < 2; i++) begin
      len = (i == 0) ? LEN_S : LEN_L;
      m_done[i] = 0;
      if (ab && m_st[i] != S_IDLE) begin
        m_st[i] = S_IDLE;
        m_tm[i] = 0;
      end else case (m_st[i])
        S_IDLE: if (st) begin m_st[i] = S_COUNTDOWN; m_tm[i] = 0; m_rem[i] = CD * FPS; end
        S_COUNTDOWN: if (tick) begin
          m_rem[i]--;
          if (m_rem[i] == 0) m_st[i] = S_PLAY;
        end
        S_PLAY: if (tick && m_tm[i] == len) begin
          m_st[i] = S_END_HOLD;
          m_done[i] = 1;
          m_hold[i] = EH;
        end else begin
          if (tick) m_tm[i]++;
          if (pa) m_st[i] = S_PAUSE;
        end
        S_PAUSE: if (pa || st) begin m_st[i] = S_COUNTDOWN; m_rem[i] = CD * FPS; end
        S_END_HOLD: if (st) begin
          m_st[i] = S_COUNTDOWN;
          m_tm[i] = 0;
          m_rem[i] = CD * FPS;
        end else if (tick) begin
          m_hold[i]--;
          if (m_hold[i] == 0) begin m_st[i] = S_IDLE; m_tm[i] = 0; end
        end
        default: ;
      endcase
    end
    m_ft = h[1] & ~h[2];
    h[3] = h[2];
    h[2] = h[1];
    h[1] = h[0];
    h[0] = nf;
    p_s = sk;
    p_p = pk;
    p_a = ak;
  endtask
  task automatic step(input logic n, input logic s, input logic p, input logic a);
    nf = n;
    sk = s;
    pk = p;
    ak = a;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
    chk("cyc_s", obs_s, exp_vec(0));
    chk("cyc_l", obs_l, exp_vec(1));
    if (sd_s) n_done++;
    if (ft_s) n_tick++;
    if (ft_s && !ft_prev) n_rise++;
    ft_prev = ft_s;
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask
  task automatic press(input int which);
    step(1'b0, which == 0, which == 1, which == 2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    logic r_n, r_s, r_p, r_a;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_state", so_s, S_IDLE);
    chk("rst_time", tm_s, 0);
    chk("rst_tick", ft_s, 0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    press(0);
    chk("cd_state", so_s, S_COUNTDOWN);
    frames(59);
    chk("cd3", cs_s, 3);
    frames(1);
    chk("cd2", cs_s, 2);
    frames(60);
    chk("cd1", cs_s, 1);
    frames(60);
    chk("play_state", so_s, S_PLAY);
    chk("play_audio", ar_s, 1);
    chk("play_time", tm_s, 0);
    chk("play_csec", cs_s, 0);
    frames(5);
    chk("t5", tm_s, 5);
    press(1);
    chk("pause_state", so_s, S_PAUSE);
    frames(20);
    chk("pause_frozen", tm_s, 5);
    chk("pause_audio", ar_s, 0);
    press(1);
    chk("resume_cd", cs_s, 3);
    chk("resume_state", so_s, S_COUNTDOWN);
    frames(180);
    chk("resume_play", so_s, S_PLAY);
    chk("resume_time", tm_s, 5);
    frames(1);
    chk("t6", tm_s, 6);
    frames(1);
    chk("t7", tm_s, 7);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp_time", tm_s, 8);
    chk("tp_state", so_s, S_PAUSE);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("as_state", so_s, S_IDLE);
    chk("as_time", tm_l, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    press(0);
    frames(180);
    frames(10);
    chk("end_t10", tm_s, 10);
    n_done = 0;
    frames(1);
    chk("done_once", n_done, 1);
    chk("end_state", so_s, S_END_HOLD);
    chk("end_hold_t", tm_s, 10);
    frames(3);
    chk("end_still", so_s, S_END_HOLD);
    frames(1);
    chk("end_idle", so_s, S_IDLE);
    chk("end_zero", tm_s, 0);
    frames(25);
    chk("long_40", tm_l, 40);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", so_l, S_IDLE);
    chk("arst_time", tm_l, 0);
    chk("arst_audio", ar_l, 0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst_after", tm_l, 0);
    n_tick = 0;
    n_rise = 0;
    repeat (3) begin
      repeat (50) step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (50) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("ft_cycles", n_tick, 3);
    chk("ft_pulses", n_rise, 3);
    press(0);
    frames(180);
    chk("held_play", so_s, S_PLAY);
    repeat (100) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("held_pause", so_s, S_PAUSE);
    press(2);
    chk("held_abort", so_s, S_IDLE);
    {r_n, r_s, r_p, r_a} = '0;
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 3) == 0) r_n = ~r_n;
      if ($urandom_range(0, 399) == 0) r_s = ~r_s;
      if ($urandom_range(0, 1499) == 0) r_p = ~r_p;
      if ($urandom_range(0, 5999) == 0) r_a = ~r_a;
      step(r_n, r_s, r_p, r_a);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
